mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares one single-ported, fixed-latency memory device (RAM port or debug-memory window) between the core instruction-fetch port and a data-side host port. It grants at most one request per cycle, steers the winner onto the memory port, and returns the response to the correct requester one cycle later. It also keeps a saturating instruction-stall counter for performance analysis.

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one single-ported memory; optional round-robin under `MEM_PORT_ARB_RR_EN.
// Grant latency 0 cycles (combinational from request), response latency 1 cycle after grant.
// Losing requester holds req until granted; fixed priority lets data starve fetch, round-robin bounds it to 1 cycle.
module mem_port_arbiter #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int StallCntWidth = 16
) (
    input  logic                     clk_sys_i,
    input  logic                     rst_sys_ni,

    input  logic                     instr_req_i,
    input  logic [AddrWidth-1:0]     instr_addr_i,
    output logic                     instr_gnt_o,
    output logic                     instr_rvalid_o,
    output logic [DataWidth-1:0]     instr_rdata_o,

    input  logic                     data_req_i,
    input  logic                     data_we_i,
    input  logic [DataWidth/8-1:0]   data_be_i,
    input  logic [AddrWidth-1:0]     data_addr_i,
    input  logic [DataWidth-1:0]     data_wdata_i,
    output logic                     data_gnt_o,
    output logic                     data_rvalid_o,
    output logic [DataWidth-1:0]     data_rdata_o,

    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [DataWidth/8-1:0]   mem_be_o,
    output logic [AddrWidth-1:0]     mem_addr_o,
    output logic [DataWidth-1:0]     mem_wdata_o,
    input  logic [DataWidth-1:0]     mem_rdata_i,

    input  logic                     stall_clr_i,
    output logic [StallCntWidth-1:0] instr_stall_cnt_o
);

    typedef enum logic {
        SEL_INSTR = 1'b0,
        SEL_DATA  = 1'b1
    } sel_e;

    sel_e                     r_last_winner;
    sel_e                     r_resp_sel;
    logic                     r_resp_vld;
    logic [StallCntWidth-1:0] r_stall_cnt;

    logic w_data_pri;
    logic w_instr_win;
    logic w_data_win;
    logic w_any_win;
    logic w_instr_stall;
    logic w_instr_rsp;
    logic w_data_rsp;

    // Which side wins when both request in the same cycle.
`ifdef MEM_PORT_ARB_RR_EN
    assign w_data_pri = (r_last_winner == SEL_INSTR);
`else
    logic w_unused_last_winner;
    assign w_unused_last_winner = r_last_winner;
    assign w_data_pri           = 1'b1;
`endif

    assign w_instr_win = instr_req_i & (~data_req_i | ~w_data_pri);
    assign w_data_win  = data_req_i  & (~instr_req_i | w_data_pri);
    assign w_any_win   = w_instr_win | w_data_win;

    assign instr_gnt_o = w_instr_win;
    assign data_gnt_o  = w_data_win;
    assign mem_req_o   = w_any_win;

    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = instr_addr_i;
        mem_wdata_o = '0;
        if (w_instr_win) begin
            mem_be_o = '1;
        end else if (w_data_win) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    // Remember who was granted so next cycle's memory data goes back to them.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            r_resp_vld    <= 1'b0;
            r_resp_sel    <= SEL_INSTR;
            r_last_winner <= SEL_INSTR;
        end else begin
            r_resp_vld <= w_any_win;
            if (w_any_win) begin
                r_resp_sel    <= w_data_win ? SEL_DATA : SEL_INSTR;
                r_last_winner <= w_data_win ? SEL_DATA : SEL_INSTR;
            end
        end
    end

    assign w_instr_rsp    = r_resp_vld & (r_resp_sel == SEL_INSTR);
    assign w_data_rsp     = r_resp_vld & (r_resp_sel == SEL_DATA);
    assign instr_rvalid_o = w_instr_rsp;
    assign data_rvalid_o  = w_data_rsp;
    assign instr_rdata_o  = w_instr_rsp ? mem_rdata_i : '0;
    assign data_rdata_o   = w_data_rsp  ? mem_rdata_i : '0;

    // Saturating stall counter; clear takes precedence over a concurrent stall.
    assign w_instr_stall = instr_req_i & ~w_instr_win;

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            r_stall_cnt <= '0;
        end else if (stall_clr_i) begin
            r_stall_cnt <= '0;
        end else if (w_instr_stall && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + StallCntWidth'(1);
        end
    end

    assign instr_stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 4-bit stall counter; expectations cover both arbitration builds.
module tb_mem_port_arbiter;

    logic        clk_sys_i;
    logic        rst_sys_ni;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        stall_clr_i;
    logic [3:0]  instr_stall_cnt_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [3:0]  exp_data_gnt;
    logic [31:0] exp_stall;

    mem_port_arbiter #(
        .AddrWidth    (32),
        .DataWidth    (32),
        .StallCntWidth(4)
    ) dut (
        .clk_sys_i        (clk_sys_i),
        .rst_sys_ni       (rst_sys_ni),
        .instr_req_i      (instr_req_i),
        .instr_addr_i     (instr_addr_i),
        .instr_gnt_o      (instr_gnt_o),
        .instr_rvalid_o   (instr_rvalid_o),
        .instr_rdata_o    (instr_rdata_o),
        .data_req_i       (data_req_i),
        .data_we_i        (data_we_i),
        .data_be_i        (data_be_i),
        .data_addr_i      (data_addr_i),
        .data_wdata_i     (data_wdata_i),
        .data_gnt_o       (data_gnt_o),
        .data_rvalid_o    (data_rvalid_o),
        .data_rdata_o     (data_rdata_o),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_be_o         (mem_be_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_rdata_i      (mem_rdata_i),
        .stall_clr_i      (stall_clr_i),
        .instr_stall_cnt_o(instr_stall_cnt_o)
    );

    initial clk_sys_i = 1'b0;
    always #5 clk_sys_i = ~clk_sys_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_sys_i);
    endtask

    task automatic idle_inputs();
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0000_ABC0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
        stall_clr_i  = 1'b0;
    endtask

    initial begin
        rst_sys_ni  = 1'b0;
        mem_rdata_i = 32'h0;
        idle_inputs();

        // Reset values
        repeat (3) @(posedge clk_sys_i);
        settle();
        check_eq("rst_instr_gnt",  32'(instr_gnt_o), 32'h0);
        check_eq("rst_data_gnt",   32'(data_gnt_o), 32'h0);
        check_eq("rst_instr_rvld", 32'(instr_rvalid_o), 32'h0);
        check_eq("rst_data_rvld",  32'(data_rvalid_o), 32'h0);
        check_eq("rst_instr_rdat", instr_rdata_o, 32'h0);
        check_eq("rst_data_rdat",  data_rdata_o, 32'h0);
        check_eq("rst_mem_req",    32'(mem_req_o), 32'h0);
        check_eq("rst_mem_we",     32'(mem_we_o), 32'h0);
        check_eq("rst_mem_be",     32'(mem_be_o), 32'h0);
        check_eq("rst_stall",      32'(instr_stall_cnt_o), 32'h0);
        tick();
        rst_sys_ni = 1'b1;

        // Continuous conflict for 4 cycles, starting from last_winner = instr
`ifdef MEM_PORT_ARB_RR_EN
        exp_data_gnt = 4'b0101;
        exp_stall    = 32'd2;
`else
        exp_data_gnt = 4'b1111;
        exp_stall    = 32'd4;
`endif
        for (int k = 0; k < 4; k++) begin
            tick();
            instr_req_i  = 1'b1;
            instr_addr_i = 32'h0000_0100;
            data_req_i   = 1'b1;
            data_we_i    = 1'b0;
            data_be_i    = 4'hF;
            data_addr_i  = 32'h0000_0200 + 32'(k * 4);
            mem_rdata_i  = 32'h0000_1000 + 32'(k);
            settle();
            check_eq($sformatf("cf_data_gnt%0d", k), 32'(data_gnt_o), 32'(exp_data_gnt[k]));
            check_eq($sformatf("cf_instr_gnt%0d", k), 32'(instr_gnt_o), 32'(!exp_data_gnt[k]));
            check_eq($sformatf("cf_mem_addr%0d", k), mem_addr_o,
                     exp_data_gnt[k] ? data_addr_i : instr_addr_i);
            if (k > 0) begin
                check_eq($sformatf("cf_data_rvld%0d", k), 32'(data_rvalid_o), 32'(exp_data_gnt[k-1]));
                check_eq($sformatf("cf_data_rdat%0d", k), data_rdata_o,
                         exp_data_gnt[k-1] ? mem_rdata_i : 32'h0);
                check_eq($sformatf("cf_instr_rdat%0d", k), instr_rdata_o,
                         exp_data_gnt[k-1] ? 32'h0 : mem_rdata_i);
            end
        end
        tick();
        idle_inputs();
        mem_rdata_i = 32'h0000_1004;
        settle();
        check_eq("cf_last_data_rvld",  32'(data_rvalid_o), 32'(exp_data_gnt[3]));
        check_eq("cf_last_instr_rvld", 32'(instr_rvalid_o), 32'(!exp_data_gnt[3]));
        check_eq("cf_stall_cnt",       32'(instr_stall_cnt_o), exp_stall);
        check_eq("idle_mem_req",       32'(mem_req_o), 32'h0);
        check_eq("idle_mem_be",        32'(mem_be_o), 32'h0);
        check_eq("idle_mem_addr",      mem_addr_o, 32'h0000_ABC0);

        // Clear, then saturate the 4-bit counter
        tick();
        stall_clr_i = 1'b1;
        tick();
        stall_clr_i = 1'b0;
        settle();
        check_eq("clr_stall", 32'(instr_stall_cnt_o), 32'h0);
        for (int k = 0; k < 40; k++) begin
            tick();
            instr_req_i = 1'b1;
            data_req_i  = 1'b1;
        end
        tick();
        stall_clr_i = 1'b1;
        settle();
        check_eq("sat_stall", 32'(instr_stall_cnt_o), 32'hF);
        tick();
        idle_inputs();
        settle();
        check_eq("clr_vs_stall", 32'(instr_stall_cnt_o), 32'h0);

        // Fetch only
        tick();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0010_0080;
        mem_rdata_i  = 32'h0;
        settle();
        check_eq("f_instr_gnt", 32'(instr_gnt_o), 32'h1);
        check_eq("f_data_gnt",  32'(data_gnt_o), 32'h0);
        check_eq("f_mem_req",   32'(mem_req_o), 32'h1);
        check_eq("f_mem_be",    32'(mem_be_o), 32'hF);
        check_eq("f_mem_we",    32'(mem_we_o), 32'h0);
        check_eq("f_mem_addr",  mem_addr_o, 32'h0010_0080);
        check_eq("f_mem_wdata", mem_wdata_o, 32'h0);
        tick();
        idle_inputs();
        mem_rdata_i = 32'hDEAD_BEEF;
        settle();
        check_eq("f_instr_rvld", 32'(instr_rvalid_o), 32'h1);
        check_eq("f_instr_rdat", instr_rdata_o, 32'hDEAD_BEEF);
        check_eq("f_data_rvld",  32'(data_rvalid_o), 32'h0);
        check_eq("f_data_rdat",  data_rdata_o, 32'h0);
        check_eq("f_stall",      32'(instr_stall_cnt_o), 32'h0);

        // Data write
        tick();
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_be_i    = 4'h3;
        data_addr_i  = 32'h0010_0010;
        data_wdata_i = 32'h0000_1234;
        mem_rdata_i  = 32'h0;
        settle();
        check_eq("w_data_gnt",  32'(data_gnt_o), 32'h1);
        check_eq("w_instr_gnt", 32'(instr_gnt_o), 32'h0);
        check_eq("w_mem_req",   32'(mem_req_o), 32'h1);
        check_eq("w_mem_we",    32'(mem_we_o), 32'h1);
        check_eq("w_mem_be",    32'(mem_be_o), 32'h3);
        check_eq("w_mem_addr",  mem_addr_o, 32'h0010_0010);
        check_eq("w_mem_wdata", mem_wdata_o, 32'h0000_1234);
        tick();
        idle_inputs();
        settle();
        check_eq("w_data_rvld",  32'(data_rvalid_o), 32'h1);
        check_eq("w_instr_rvld", 32'(instr_rvalid_o), 32'h0);

        // Reset the cycle after a fetch grant drops the pending response
        tick();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0010_0040;
        settle();
        check_eq("r_instr_gnt", 32'(instr_gnt_o), 32'h1);
        tick();
        idle_inputs();
        rst_sys_ni  = 1'b0;
        mem_rdata_i = 32'hCAFE_F00D;
        settle();
        check_eq("r_instr_rvld_in", 32'(instr_rvalid_o), 32'h0);
        check_eq("r_instr_rdat_in", instr_rdata_o, 32'h0);
        check_eq("r_mem_req_in",    32'(mem_req_o), 32'h0);
        tick();
        rst_sys_ni = 1'b1;
        settle();
        check_eq("r_instr_rvld_out", 32'(instr_rvalid_o), 32'h0);
        check_eq("r_data_rvld_out",  32'(data_rvalid_o), 32'h0);
        check_eq("r_stall_out",      32'(instr_stall_cnt_o), 32'h0);
        tick();
        settle();
        check_eq("r_instr_rvld_2", 32'(instr_rvalid_o), 32'h0);

        // Alternating single requests: instr, data read, instr
        tick();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0300;
        settle();
        check_eq("a0_instr_gnt", 32'(instr_gnt_o), 32'h1);
        tick();
        idle_inputs();
        data_req_i  = 1'b1;
        data_be_i   = 4'hF;
        data_addr_i = 32'h0000_0400;
        mem_rdata_i = 32'hA000_0001;
        settle();
        check_eq("a1_data_gnt",   32'(data_gnt_o), 32'h1);
        check_eq("a1_instr_rvld", 32'(instr_rvalid_o), 32'h1);
        check_eq("a1_instr_rdat", instr_rdata_o, 32'hA000_0001);
        check_eq("a1_data_rvld",  32'(data_rvalid_o), 32'h0);
        tick();
        idle_inputs();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0304;
        mem_rdata_i  = 32'hA000_0002;
        settle();
        check_eq("a2_instr_gnt",  32'(instr_gnt_o), 32'h1);
        check_eq("a2_data_rvld",  32'(data_rvalid_o), 32'h1);
        check_eq("a2_data_rdat",  data_rdata_o, 32'hA000_0002);
        check_eq("a2_instr_rvld", 32'(instr_rvalid_o), 32'h0);
        check_eq("a2_instr_rdat", instr_rdata_o, 32'h0);
        tick();
        idle_inputs();
        mem_rdata_i = 32'hA000_0003;
        settle();
        check_eq("a3_instr_rvld", 32'(instr_rvalid_o), 32'h1);
        check_eq("a3_instr_rdat", instr_rdata_o, 32'hA000_0003);
        check_eq("a3_data_rvld",  32'(data_rvalid_o), 32'h0);
        tick();
        settle();
        check_eq("a4_instr_rvld", 32'(instr_rvalid_o), 32'h0);
        check_eq("a4_data_rvld",  32'(data_rvalid_o), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
